cap_ctrl: RTL and testbench
===========================

Name: cap_ctrl

Overview:
- Parametrised capture controller for the logic analyzer; supersedes the fixed 5-channel capture/trigger pair.
- Combines per-channel trigger qualification (AND/OR with enable mask, plus external/protocol trigger) with circular-buffer RAM write sequencing, pre-trigger fill and post-trigger countdown.
- Sits between the channel trigger units, the command config block and the channel RAMs; drives the shared we/waddr to all RAMs.

Parameters:
- NUM_CH, 5, number of channel trigger inputs.
- DEPTH, 384, RAM entries per channel; 12288 on DE-0.
- LOG2, 9, address width; DEPTH <= 2^LOG2.

Ports:
- clk  in  1  system clock (100MHz).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begin capture.
- stop  in  1  single-cycle pulse; abort capture.
- clr_done  in  1  pulse; acknowledge done, return to idle.
- wrt_smpl  in  1  sample-write timing strobe.
- chan_trig  in  NUM_CH  per-channel trigger hits.
- trig_mask  in  NUM_CH  1 = channel participates.
- trig_all  in  1  1 = AND of enabled channels, 0 = OR.
- ext_trig  in  1  protocol/external trigger.
- ext_trig_en  in  1  enables ext_trig.
- trig_pos  in  LOG2  pre-trigger sample count.
- we  out  1  RAM write enable.
- waddr  out  LOG2  RAM write address.
- armed  out  1  trigger evaluation active.
- triggered  out  1  trigger has fired this capture.
- capture_done  out  1  buffer complete.
- trig_addr  out  LOG2  waddr captured at trigger.
- trig_wait  out  16  strobes spent armed (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high. On reset: state IDLE; we, waddr, armed, triggered, capture_done, trig_addr and trig_wait are all 0.
- Write path:
  - we = wrt_smpl when state is PRETRIG, ARMED or POST; combinational, same cycle.
  - waddr increments on the clock edge after each write.
  - Wrap: DEPTH-1 -> 0.
- trig_hit:
  - Channel term: trig_all=1 requires &(chan_trig | ~trig_mask) and |trig_mask; trig_all=0 uses |(chan_trig & trig_mask).
  - ext_trig & ext_trig_en is ORed with the channel term.
  - Mask all zero with ext disabled never triggers.
- Effective pre-trigger count: tp = min(trig_pos, DEPTH-1).
- State IDLE:
  - start -> PRETRIG; waddr <= 0, smpl_cnt <= 0, triggered <= 0, capture_done <= 0.
- State PRETRIG:
  - Each write increments smpl_cnt.
  - When smpl_cnt == tp (checked every cycle) -> ARMED and armed <= 1.
  - tp = 0: ARMED on the cycle after start.
- State ARMED:
  - Writes continue and wrap over the oldest data.
  - trig_hit -> POST; triggered <= 1, trig_addr <= waddr, post_cnt <= 0.
  - A write in the trigger cycle lands at trig_addr.
- State POST:
  - armed stays 1.
  - Each write increments post_cnt.
  - When post_cnt reaches DEPTH - tp -> DONE; armed <= 0, capture_done <= 1.
  - trig_hit is ignored.
- State DONE:
  - we = 0; outputs held.
  - clr_done -> IDLE, capture_done <= 0; triggered and trig_addr are kept for readout.
  - start is ignored.
- stop, any state: -> IDLE next cycle; armed, triggered and capture_done <= 0; waddr holds.
- Priority: stop > clr_done > start > trig_hit.
- start while in PRETRIG, ARMED or POST is ignored.
- Counter widths: smpl_cnt and post_cnt are LOG2+1 bits; comparisons are unsigned.

Optional Feature:
- Macro: CAP_TRIG_CNT_EN.
- Defined:
  - 16-bit trig_wait clears on start and increments on each wrt_smpl while in ARMED.
  - Saturates at 0xFFFF.
  - Frozen from trigger until the next start.
- Undefined: trig_wait is tied to 0 and no counter logic is built.

Test Plan:
- DEPTH=384, trig_pos=100, OR mask=5'b00001, wrt_smpl every 4th cycle, chan_trig[0] pulse after 150 strobes -> armed after 100 writes; trig_addr=150; capture_done after 284 further writes; final waddr=(150+284)%384=50.
- trig_all=1, mask=5'b00110, chan_trig=5'b00010 then 5'b00110 -> no trigger on first pattern; trigger on second.
- mask=0, ext_trig_en=0, ext_trig=1 -> remains ARMED indefinitely; we keeps toggling; waddr wraps 383 -> 0.
- stop asserted mid-POST, same cycle as start -> IDLE; armed=0, triggered=0, capture_done=0; no further we.
- trig_pos=0, ext trigger asserted the cycle armed rises -> POST immediately; done after 384 writes; trig_addr=0.
- CAP_TRIG_CNT_EN defined, trigger after 70000 armed strobes -> trig_wait=0xFFFF; rst mid-capture -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cap_ctrl.sv
// Capture controller: trigger qualification plus circular-buffer write sequencing for the channel RAMs.
// Optional CAP_TRIG_CNT_EN builds the trig_wait counter of strobes spent armed; otherwise trig_wait is 0.
//
// state   | meaning
// IDLE    | waiting for start, no writes
// PRETRIG | filling tp pre-trigger samples
// ARMED   | writing circularly, evaluating trigger
// POST    | counting DEPTH-tp post-trigger writes
// DONE    | buffer complete, held for readout
module cap_ctrl #(
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 384,
    parameter int LOG2   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clr_done,
    input  logic              wrt_smpl,
    input  logic [NUM_CH-1:0] chan_trig,
    input  logic [NUM_CH-1:0] trig_mask,
    input  logic              trig_all,
    input  logic              ext_trig,
    input  logic              ext_trig_en,
    input  logic [LOG2-1:0]   trig_pos,
    output logic              we,
    output logic [LOG2-1:0]   waddr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic [LOG2-1:0]   trig_addr,
    output logic [15:0]       trig_wait
);

    typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POST, DONE} state_t;

    localparam logic [LOG2:0]   LAST_CNT  = (LOG2+1)'(DEPTH - 1);
    localparam logic [LOG2:0]   DEPTH_CNT = (LOG2+1)'(DEPTH);
    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(DEPTH - 1);

    state_t          state;
    logic [LOG2:0]   smpl_cnt;
    logic [LOG2:0]   post_cnt;
    logic [LOG2:0]   tp;
    logic [LOG2:0]   post_target;
    logic [LOG2-1:0] next_addr;
    logic            chan_and;
    logic            chan_or;
    logic            trig_hit;

    // A mask of all zeros must not satisfy the AND mode vacuously.
    always_comb begin
        chan_and = (&(chan_trig | ~trig_mask)) & (|trig_mask);
        chan_or  = |(chan_trig & trig_mask);
        trig_hit = (trig_all ? chan_and : chan_or) | (ext_trig & ext_trig_en);
    end

    always_comb begin
        tp          = ({1'b0, trig_pos} > LAST_CNT) ? LAST_CNT : {1'b0, trig_pos};
        post_target = DEPTH_CNT - tp;
        next_addr   = (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        we          = wrt_smpl & ((state == PRETRIG) | (state == ARMED) | (state == POST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            waddr        <= '0;
            smpl_cnt     <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            trig_addr    <= '0;
        end else if (stop) begin
            state        <= IDLE;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            if (we) begin
                waddr <= next_addr;
            end
            case (state)
                IDLE: begin
                    if (start && !clr_done) begin
                        state        <= PRETRIG;
                        waddr        <= '0;
                        smpl_cnt     <= '0;
                        triggered    <= 1'b0;
                        capture_done <= 1'b0;
                    end
                end
                PRETRIG: begin
                    if (smpl_cnt == tp) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end else if (we) begin
                        smpl_cnt <= smpl_cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        state     <= POST;
                        triggered <= 1'b1;
                        trig_addr <= waddr;
                        post_cnt  <= '0;
                    end
                end
                POST: begin
                    // Finish on the write that completes the window so no extra sample lands.
                    if (we) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == post_target) begin
                            state        <= DONE;
                            armed        <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        state        <= IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAP_TRIG_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_wait <= '0;
        end else if (state == IDLE && start && !clr_done) begin
            trig_wait <= '0;
        end else if (state == ARMED && wrt_smpl && trig_wait != 16'hFFFF) begin
            trig_wait <= trig_wait + 16'd1;
        end
    end
`else
    assign trig_wait = '0;
`endif

endmodule

// File: tb/tb_cap_ctrl.sv
// Self-checking bench for cap_ctrl: directed capture sequences, a trigger-qualification table
// and a randomized run against a behavioural model.
module tb_cap_ctrl;
    localparam int NUM_CH = 5;
    localparam int DEPTH  = 384;
    localparam int LOG2   = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 0, stop = 0, clr_done = 0, wrt_smpl = 0;
    logic [NUM_CH-1:0] chan_trig = '0, trig_mask = '0;
    logic              trig_all = 0, ext_trig = 0, ext_trig_en = 0;
    logic [LOG2-1:0]   trig_pos = '0;
    logic              we, armed, triggered, capture_done;
    logic [LOG2-1:0]   waddr, trig_addr;
    logic [15:0]       trig_wait;

    int n_cmp = 0;
    int n_bad = 0;

    cap_ctrl #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .LOG2(LOG2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_done(clr_done),
        .wrt_smpl(wrt_smpl), .chan_trig(chan_trig), .trig_mask(trig_mask),
        .trig_all(trig_all), .ext_trig(ext_trig), .ext_trig_en(ext_trig_en),
        .trig_pos(trig_pos), .we(we), .waddr(waddr), .armed(armed),
        .triggered(triggered), .capture_done(capture_done), .trig_addr(trig_addr),
        .trig_wait(trig_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              all;
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] chan;
        logic              ext;
        logic              ext_en;
        logic              exp_trig;
    } trig_vec_t;

    trig_vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic strobe4(input int n);
        for (int i = 0; i < n; i++) begin
            wrt_smpl = 1'b1;
            tick();
            wrt_smpl = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Behavioural model: phases 0 idle, 1 pre-fill, 2 armed, 3 post, 4 done.
    int m_phase, m_addr, m_pre, m_post, m_taddr, m_tw;
    bit m_armed, m_trig, m_done;

    task automatic model_reset();
        m_phase = 0; m_addr = 0; m_pre = 0; m_post = 0; m_taddr = 0; m_tw = 0;
        m_armed = 0; m_trig = 0; m_done = 0;
    endtask

    function automatic bit model_hit();
        int en = 0;
        int hits = 0;
        bit ch;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_mask[i]) en++;
            if (trig_mask[i] && chan_trig[i]) hits++;
        end
        ch = trig_all ? (en > 0 && hits == en) : (hits > 0);
        return ch || (ext_trig && ext_trig_en);
    endfunction

    function automatic bit model_we();
        return wrt_smpl && (m_phase >= 1 && m_phase <= 3);
    endfunction

    task automatic model_step();
        int tp;
        bit wr;
        bit hit;
        int ph;
        tp  = (int'(trig_pos) > DEPTH - 1) ? DEPTH - 1 : int'(trig_pos);
        wr  = model_we();
        hit = model_hit();
        ph  = m_phase;
`ifdef CAP_TRIG_CNT_EN
        if (ph == 0 && start && !clr_done) m_tw = 0;
        else if (ph == 2 && wrt_smpl && m_tw < 65535) m_tw++;
`endif
        if (stop) begin
            m_phase = 0; m_armed = 0; m_trig = 0; m_done = 0;
        end else begin
            if (ph == 2 && hit) begin
                m_taddr = m_addr;
                m_post  = 0;
                m_trig  = 1;
                m_phase = 3;
            end
            if (wr) m_addr = (m_addr + 1) % DEPTH;
            if (ph == 0 && start && !clr_done) begin
                m_phase = 1; m_addr = 0; m_pre = 0; m_trig = 0; m_done = 0;
            end else if (ph == 1) begin
                if (m_pre == tp) begin
                    m_phase = 2; m_armed = 1;
                end else if (wr) m_pre++;
            end else if (ph == 3 && wr) begin
                m_post++;
                if (m_post == DEPTH - tp) begin
                    m_phase = 4; m_armed = 0; m_done = 1;
                end
            end else if (ph == 4 && clr_done) begin
                m_phase = 0; m_done = 0;
            end
        end
    endtask

    task automatic model_compare();
        chk("rnd_we",        we,           model_we());
        chk("rnd_waddr",     waddr,        m_addr);
        chk("rnd_armed",     armed,        m_armed);
        chk("rnd_triggered", triggered,    m_trig);
        chk("rnd_done",      capture_done, m_done);
        chk("rnd_trig_addr", trig_addr,    m_taddr);
        chk("rnd_trig_wait", trig_wait,    m_tw);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 5'b00001, 5'b11110, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'b00110, 5'b00010, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'b00110, 5'b00110, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'b00110, 5'b11111, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'b00000, 5'b11111, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'b00000, 5'b11111, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'b11111, 5'b11110, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 5'b11111, 5'b11111, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 5'b10100, 5'b00100, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 5'b11111, 5'b01111, 1'b0, 1'b0, 1'b0};

        tick();
        chk("rst_waddr", waddr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_trig_wait", trig_wait, 0);
        wrt_smpl = 1'b1;
        #1 chk("rst_we", we, 0);
        wrt_smpl = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Main capture: 100 pre-trigger writes, trigger at 150, 284 post writes.
        trig_pos = 9'd100; trig_mask = 5'b00001; trig_all = 1'b0;
        pulse_start();
        strobe4(99);
        chk("pre_not_armed", armed, 0);
        strobe4(1);
        chk("pre_armed", armed, 1);
        chk("pre_waddr", waddr, 100);
        strobe4(50);
        chan_trig = 5'b00001;
        tick();
        chan_trig = '0;
        chk("main_triggered", triggered, 1);
        chk("main_trig_addr", trig_addr, 150);
        strobe4(283);
        chk("main_not_done", capture_done, 0);
        strobe4(1);
        chk("main_done", capture_done, 1);
        chk("main_final_waddr", waddr, 50);
        chk("main_armed_off", armed, 0);
        wrt_smpl = 1'b1;
        #1 chk("done_no_we", we, 0);
        wrt_smpl = 1'b0;
        pulse_start();
        chk("done_ignores_start", capture_done, 1);
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        chk("clr_done", capture_done, 0);
        chk("clr_keeps_trig", triggered, 1);
        chk("clr_keeps_addr", trig_addr, 150);

        // Trigger qualification table, each from a fresh tp=0 capture.
        trig_pos = '0;
        for (int v = 0; v < 12; v++) begin
            pulse_start();
            tick();
            chk($sformatf("vec%0d_armed", v), armed, 1);
            trig_all = vecs[v].all; trig_mask = vecs[v].mask; chan_trig = vecs[v].chan;
            ext_trig = vecs[v].ext; ext_trig_en = vecs[v].ext_en;
            tick();
            chk($sformatf("vec%0d_trig", v), triggered, vecs[v].exp_trig);
            trig_all = 0; trig_mask = '0; chan_trig = '0; ext_trig = 0; ext_trig_en = 0;
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end

        // Never-triggering configuration keeps writing and wraps the address.
        ext_trig = 1'b1;
        pulse_start();
        tick();
        wrt_smpl = 1'b1;
        #1 chk("wrap_we", we, 1);
        repeat (383) tick();
        chk("wrap_waddr_383", waddr, 383);
        tick();
        chk("wrap_waddr_0", waddr, 0);
        chk("wrap_still_armed", armed, 1);
        chk("wrap_no_trig", triggered, 0);
        wrt_smpl = 1'b0;

        // Stop during POST coinciding with start.
        ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("post_trig_addr", trig_addr, 0);
        wrt_smpl = 1'b1;
        repeat (2) tick();
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop_armed", armed, 0);
        chk("stop_triggered", triggered, 0);
        chk("stop_done", capture_done, 0);
        chk("stop_waddr_hold", waddr, 2);
        #1 chk("stop_no_we", we, 0);
        tick();
        wrt_smpl = 1'b0;
        chk("stop_waddr_idle", waddr, 2);

        // tp=0 with trigger in the first armed cycle: full 384-write window.
        pulse_start();
        tick();
        ext_trig = 1'b1; ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("tp0_triggered", triggered, 1);
        chk("tp0_trig_addr", trig_addr, 0);
        wrt_smpl = 1'b1;
        repeat (383) tick();
        chk("tp0_not_done", capture_done, 0);
        tick();
        wrt_smpl = 1'b0;
        chk("tp0_done", capture_done, 1);
        chk("tp0_waddr", waddr, 0);
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;

        // trig_pos above DEPTH-1 clamps to 383 pre-trigger writes.
        trig_pos = 9'd500;
        pulse_start();
        wrt_smpl = 1'b1;
        repeat (382) tick();
        wrt_smpl = 1'b0;
        repeat (2) tick();
        chk("clamp_not_armed", armed, 0);
        wrt_smpl = 1'b1;
        tick();
        wrt_smpl = 1'b0;
        repeat (2) tick();
        chk("clamp_armed", armed, 1);
        ext_trig = 1'b1; ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("clamp_trig_addr", trig_addr, 383);
        wrt_smpl = 1'b1;
        tick();
        wrt_smpl = 1'b0;
        chk("clamp_done", capture_done, 1);
        chk("clamp_waddr", waddr, 0);

        // Randomized run against the behavioural model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 15000; c++) begin
            wrt_smpl = 1'($urandom_range(0, 1));
            stop     = ($urandom_range(0, 399) == 0);
            clr_done = (m_phase == 4) && ($urandom_range(0, 5) == 0);
            if (m_phase == 0) begin
                start       = ($urandom_range(0, 7) == 0);
                trig_pos    = LOG2'($urandom_range(0, 450));
                trig_mask   = NUM_CH'($urandom);
                trig_all    = 1'($urandom_range(0, 1));
                ext_trig_en = 1'($urandom_range(0, 1));
            end else begin
                start = ($urandom_range(0, 49) == 0);
            end
            chan_trig = ($urandom_range(0, 29) == 0) ? NUM_CH'($urandom) : '0;
            ext_trig  = ($urandom_range(0, 39) == 0);
            #1;
            model_compare();
            model_step();
            tick();
        end
        start = 0; stop = 0; clr_done = 0; wrt_smpl = 0; chan_trig = '0; ext_trig = 0;
        ext_trig_en = 0; trig_mask = '0; trig_all = 0;

        // Asynchronous reset in the middle of a capture.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        trig_pos = 9'd3;
        pulse_start();
        wrt_smpl = 1'b1;
        repeat (6) tick();
        ext_trig = 1'b1; ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("arst_pre_trig", triggered, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", we, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_armed", armed, 0);
        chk("arst_triggered", triggered, 0);
        chk("arst_trig_addr", trig_addr, 0);
        chk("arst_trig_wait", trig_wait, 0);
        wrt_smpl = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef CAP_TRIG_CNT_EN
        trig_pos = '0;
        pulse_start();
        tick();
        wrt_smpl = 1'b1;
        repeat (5) tick();
        wrt_smpl = 1'b0;
        ext_trig = 1'b1; ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("tw_count5", trig_wait, 5);
        wrt_smpl = 1'b1;
        repeat (3) tick();
        wrt_smpl = 1'b0;
        chk("tw_frozen", trig_wait, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        pulse_start();
        chk("tw_clear_on_start", trig_wait, 0);
        tick();
        wrt_smpl = 1'b1;
        repeat (70000) tick();
        wrt_smpl = 1'b0;
        chk("tw_saturate", trig_wait, 16'hFFFF);
        ext_trig = 1'b1; ext_trig_en = 1'b1;
        tick();
        ext_trig = 1'b0; ext_trig_en = 1'b0;
        chk("tw_sat_triggered", triggered, 1);
        chk("tw_sat_hold", trig_wait, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
